ram_access_ctrl: RTL and testbench
==================================

# ram_access_ctrl

Byte-addressed load/store requester that drives one port of the team's dual-port block RAM (word-addressed, 4×8-bit columns, synchronous read, column write enables). It converts CPU-side byte, half and word accesses, aligned or misaligned, into sequences of legal RAM port cycles. It also sign- or zero-extends load data. It sits between the core's memory stage and RAM port A.

## Interface
Parameters:
- ADDR_WIDTH, 12, RAM word-address bits; byte address is ADDR_WIDTH+2 bits.
- COL_WIDTH, 8, column width; fixed at 8 (4 columns, 32-bit word).

Ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH+2  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads: sign-extend byte/half.
- req_wdata  in  32  store data, least significant byte goes to the lowest address.
- rsp_valid  out  1  one-cycle completion pulse; no back-pressure.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; set for req_size 11.
- ram_en  out  1  RAM port enable.
- ram_we  out  4  column write enables.
- ram_addr  out  ADDR_WIDTH  word address.
- ram_din  out  32  write data, already lane-shifted.
- ram_dout  in  32  RAM read data, valid the cycle after the read edge.

## Operation
- Word w = req_addr[ADDR_WIDTH+1:2]; offset o = req_addr[1:0]. The next word is w+1 modulo 2^ADDR_WIDTH, so it wraps from the top word to 0.
- Legal write masks are only 0001, 0010, 0100, 1000, 0011, 1100, 1111. The RAM ignores any other mask, so ram_we must never present another value.
- Stores build an 8-bit pending byte mask over {w+1, w} from the size and offset.
- Each write beat writes one greedy chunk, chosen from the lowest pending byte:
  - 1111 if the whole word is pending;
  - else 0011 or 1100 if that aligned half is fully pending;
  - else the single byte.
- Beat count per store: 1 to 3.
- Loads always read full words: one read, or two if o + bytes > 4. The result is ({w+1, w} >> 8·o), masked to the access size, then extended per req_signed.
- States:
  - IDLE: request accepted → first beat issued in the same cycle.
  - WR: remaining store beats.
  - RD1: first read data arriving.
  - RD2: second read data arriving.
- Transitions:
  - Store: IDLE → WR if beats remain, else IDLE.
  - Load: IDLE → RD1 → RD2 (only if two words are needed) → IDLE.
  - req_size 11: accepted; no RAM cycle; rsp_err pulse on the next cycle; stays in IDLE.
- RAM outputs are combinational from state plus registered request fields. In IDLE they come from the req_* inputs, gated by req_valid.
- During a load, ram_we = 0. In RD1, when a second word is needed, ram_en=1 and ram_addr=w+1.
- Reset:
  - IDLE; rsp_valid = 0, rsp_err = 0, rsp_rdata = 0; req_ready = 1 after release.
  - Asserting rst_n low mid-store aborts the remaining beats. Bytes already written stay written.

## Timing
- Store with n beats: beats occur on the accept edge E0 through E(n−1). rsp_valid is high in the cycle after E(n−1).
- Single-word load: RAM samples at E0, result is formatted at E1, rsp_valid is high after E1.
- Two-word load: word w is captured at E1 while w+1 is read. The result is merged at E2 and rsp_valid is high after E2.
- req_ready returns high in the same cycle as rsp_valid, so back-to-back requests lose no cycle.
- rsp_rdata holds its value until the next response.

## Structure
- Package ram_access_pkg holds:
  - size encodings (SIZE_B, SIZE_H, SIZE_W);
  - the state enum;
  - the legal-mask constants.
- Sub-module ram_store_chunker: combinational. Takes the pending 4-bit mask for the current word and returns the chunk mask plus the remaining mask.

## Test plan
- Aligned store: word 0xDEADBEEF at byte address 0x010 → one beat, ram_addr=4, ram_we=1111; rsp_valid 1 cycle later.
- Half store at offset 1: half 0xABCD at byte address 0x005, then loads from 0x005.
  - Store beats: addr 1, we 0010, byte 0xCD; then addr 1, we 0100, byte 0xAB.
  - Unsigned half load returns 0x0000ABCD; signed half load returns 0xFFFFABCD. rsp_valid is high 2 cycles after accept.
- Word store at offset 3: 0x11223344 at byte address 0x007, then a word load from 0x007.
  - Beats: addr 1 we 1000 (0x44); addr 2 we 0011 (0x33, 0x22); addr 2 we 0100 (0x11).
  - The word load returns 0x11223344 after 3 cycles, using two reads.
- Wrap-around: word load at byte address 0x3FFE with ADDR_WIDTH=12 reads word 0xFFF, then word 0x000. The merge uses the upper half of 0xFFF and the lower half of 0x000.
- Reset mid-operation: rst_n asserted low after the first beat of the offset-3 store → only addr 1 byte 3 is modified; no rsp_valid; req_ready = 1 after release.
- Illegal size: req_size=11 → ram_en stays 0; rsp_valid with rsp_err=1 and rsp_rdata=0 next cycle.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_pkg: access-size encodings, controller states, legal column
// write masks and the load-formatting helper shared by ram_access_ctrl.
package ram_access_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10,
      SIZE_X = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR,
      ST_RD1,
      ST_RD2
   } state_e;

   // The only column-enable patterns the block RAM honours.
   localparam logic [3:0] MASK_B0 = 4'b0001;
   localparam logic [3:0] MASK_B1 = 4'b0010;
   localparam logic [3:0] MASK_B2 = 4'b0100;
   localparam logic [3:0] MASK_B3 = 4'b1000;
   localparam logic [3:0] MASK_H0 = 4'b0011;
   localparam logic [3:0] MASK_H1 = 4'b1100;
   localparam logic [3:0] MASK_W  = 4'b1111;

   // Byte mask of an access starting at offset 0.
   function automatic logic [3:0] size_mask(input logic [1:0] size);
      case (size)
         SIZE_B:  size_mask = 4'b0001;
         SIZE_H:  size_mask = 4'b0011;
         SIZE_W:  size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

   // Number of bytes touched by an access.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_B:  size_bytes = 3'd1;
         SIZE_H:  size_bytes = 3'd2;
         SIZE_W:  size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

   // Align the word pair {w+1, w} to the byte offset, trim to size, extend.
   function automatic logic [31:0] format_load(input logic [63:0] pair,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        sgn);
      logic [31:0] sh;
      sh = 32'(pair >> {off, 3'b000});
      case (size)
         SIZE_B:  format_load = sgn ? {{24{sh[7]}}, sh[7:0]}  : {24'h0, sh[7:0]};
         SIZE_H:  format_load = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
         default: format_load = sh;
      endcase
   endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// CPU-side request/response bundle of ram_access_ctrl.
interface ram_access_ctrl_if #(parameter int ADDR_WIDTH = 12);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH+1:0] req_addr;
   logic [1:0]            req_size;
   logic                  req_signed;
   logic [31:0]           req_wdata;
   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_size, req_signed, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/ram_store_chunker.sv
// ram_store_chunker: picks the largest legal write chunk that starts at the
// lowest pending byte of one word and reports what is left afterwards.
module ram_store_chunker
   import ram_access_pkg::*;
(
   input  logic [3:0] pend,
   output logic [3:0] chunk,
   output logic [3:0] rest
);

   // Greedy chunk selection: full word, else aligned half, else single byte.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      chunk = 4'b0000;
      if (pend == MASK_W)     chunk = MASK_W;
      else if (pend[0])       chunk = pend[1] ? MASK_H0 : MASK_B0;
      else if (pend[1])       chunk = MASK_B1;
      else if (pend[2])       chunk = pend[3] ? MASK_H1 : MASK_B2;
      else if (pend[3])       chunk = MASK_B3;
      rest = pend & ~chunk;
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: turns byte/half/word CPU accesses (any alignment) into
// legal block-RAM port cycles and formats load data.
module ram_access_ctrl
   import ram_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int COL_WIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ram_access_ctrl_if.slave         bus,
   output logic                     ram_en,
   output logic [3:0]               ram_we,
   output logic [ADDR_WIDTH-1:0]    ram_addr,
   output logic [4*COL_WIDTH-1:0]   ram_din,
   input  logic [4*COL_WIDTH-1:0]   ram_dout
);

   state_e                state, state_next;
   logic [ADDR_WIDTH-1:0] r_word, word_p1;
   logic [1:0]            r_off, r_size;
   logic                  r_signed, r_two;
   logic [7:0]            r_pend, pend_next;
   logic [63:0]           r_data;
   logic [31:0]           r_lo;

   logic                  accept, use_hi, store_done;
   logic [ADDR_WIDTH-1:0] in_word;
   logic [7:0]            in_mask8;
   logic [63:0]           in_data64;
   logic                  in_two;
   logic [3:0]            cur_pend, chunk, rest;

   assign bus.req_ready = (state == ST_IDLE);
   assign accept        = bus.req_valid && (state == ST_IDLE);
   assign word_p1       = r_word + ADDR_WIDTH'(1);

   // Request decode: byte mask and lane-shifted data over the pair {w+1, w}.
   assign in_word   = bus.req_addr[ADDR_WIDTH+1:2];
   assign in_mask8  = {4'b0000, size_mask(bus.req_size)} << bus.req_addr[1:0];
   assign in_data64 = {32'h0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
   assign in_two    = ({1'b0, bus.req_addr[1:0]} + size_bytes(bus.req_size)) > 3'd4;

   // Select which word of the pair the current store beat targets.
   always_comb begin
      use_hi   = 1'b0;
      cur_pend = 4'b0000;
      if (state == ST_WR) begin
         use_hi   = (r_pend[3:0] == 4'b0000);
         cur_pend = use_hi ? r_pend[7:4] : r_pend[3:0];
      end else if (accept && bus.req_write) begin
         cur_pend = in_mask8[3:0];
      end
   end

   ram_store_chunker u_chunker (
      .pend  (cur_pend),
      .chunk (chunk),
      .rest  (rest)
   );

   // Next state and RAM port drive.
   always_comb begin
      state_next = state;
      ram_en     = 1'b0;
      ram_we     = 4'b0000;
      ram_addr   = r_word;
      ram_din    = '0;
      pend_next  = r_pend;
      store_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept && bus.req_size != SIZE_X) begin
               ram_en   = 1'b1;
               ram_addr = in_word;
               if (bus.req_write) begin
                  ram_we     = chunk;
                  ram_din    = in_data64[31:0];
                  pend_next  = {in_mask8[7:4], rest};
                  store_done = (pend_next == 8'h00);
                  state_next = store_done ? ST_IDLE : ST_WR;
               end else begin
                  state_next = ST_RD1;
               end
            end
         end
         ST_WR: begin
            ram_en     = 1'b1;
            ram_we     = chunk;
            ram_addr   = use_hi ? word_p1 : r_word;
            ram_din    = use_hi ? r_data[63:32] : r_data[31:0];
            pend_next  = use_hi ? {rest, 4'b0000} : {r_pend[7:4], rest};
            store_done = (pend_next == 8'h00);
            if (store_done) state_next = ST_IDLE;
         end
         ST_RD1: begin
            if (r_two) begin
               ram_en     = 1'b1;
               ram_addr   = word_p1;
               state_next = ST_RD2;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RD2:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Request capture, low-word capture and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register here is control or a small datapath field, so all
      // are reset; an abort mid-store then leaves no stale pending bytes.
      if (!rst_n) begin
         r_word        <= '0;
         r_off         <= 2'b00;
         r_size        <= 2'b00;
         r_signed      <= 1'b0;
         r_two         <= 1'b0;
         r_pend        <= 8'h00;
         r_data        <= 64'h0;
         r_lo          <= 32'h0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= 32'h0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         r_pend        <= pend_next;
         if (accept) begin
            r_word   <= in_word;
            r_off    <= bus.req_addr[1:0];
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_two    <= in_two;
            r_data   <= in_data64;
         end
         if (accept && bus.req_size == SIZE_X) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= 32'h0;
         end else if (store_done) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= 32'h0;
         end else if (state == ST_RD1 && r_two) begin
            r_lo <= ram_dout;
         end else if (state == ST_RD1 || state == ST_RD2) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= format_load((state == ST_RD2) ? {ram_dout, r_lo} : {32'h0, ram_dout},
                                         r_off, r_size, r_signed);
         end
      end
   end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a port-A block-RAM model.
module tb_ram_access_ctrl;

   localparam int AW = 12;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout;

   int total = 0;
   int bad   = 0;

   ram_access_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   ram_access_ctrl #(.ADDR_WIDTH(AW), .COL_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   always #5 clk = ~clk;

   // Block RAM: synchronous read, per-column write enables.
   logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'h0};
   always @(posedge clk) begin
      if (ram_en) begin
         for (int c = 0; c < 4; c++)
            if (ram_we[c]) mem[ram_addr][c*8 +: 8] <= ram_din[c*8 +: 8];
         ram_dout <= mem[ram_addr];
      end
   end

   // Port monitor, sampled mid-cycle.
   int            nbeats = 0;
   int            nreads = 0;
   int            nen    = 0;
   logic [AW-1:0] beat_addr [0:63];
   logic [3:0]    beat_we   [0:63];
   logic [31:0]   beat_din  [0:63];
   logic [AW-1:0] rd_addr   [0:63];
   always @(negedge clk) begin
      if (ram_en) nen++;
      if (ram_en && ram_we != 4'b0000) begin
         beat_addr[nbeats & 63] = ram_addr;
         beat_we[nbeats & 63]   = ram_we;
         beat_din[nbeats & 63]  = ram_din;
         nbeats++;
      end
      if (ram_en && ram_we == 4'b0000) begin
         rd_addr[nreads & 63] = ram_addr;
         nreads++;
      end
   end

   // Issue one request from IDLE and wait (bounded) for its response.
   task automatic do_req(input logic wr, input logic [AW+1:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wd,
                         output int cyc, output logic [31:0] rd, output logic er);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_addr   = addr;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_wdata  = wd;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      cyc = 1;
      while (bus.rsp_valid !== 1'b1 && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      total++;
      if (bus.rsp_valid !== 1'b1) begin
         bad++; $display("FAIL rsp_timeout addr=%h got no rsp_valid within %0d cycles", addr, cyc);
      end
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL ready_with_rsp addr=%h got=%b want=1", addr, bus.req_ready);
      end
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
   endtask

   task automatic test_reset();
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_size = 2'b00; bus.req_signed = 1'b0; bus.req_wdata = 32'h0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.rsp_valid); end
      total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.rsp_err); end
      total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.rsp_rdata); end
      total++; if (nen !== 0) begin bad++; $display("FAIL reset_ram_en got=%0d cycles want=0", nen); end
   endtask

   task automatic test_aligned_store();
      int b0, r0, cyc; logic [31:0] rd; logic er;
      b0 = nbeats;
      do_req(1'b1, 14'h010, 2'b10, 1'b0, 32'hDEADBEEF, cyc, rd, er);
      total++; if (cyc !== 1) begin bad++; $display("FAIL aligned_latency got=%0d want=1", cyc); end
      total++; if (nbeats - b0 !== 1) begin bad++; $display("FAIL aligned_beats got=%0d want=1", nbeats - b0); end
      total++; if (beat_addr[b0] !== 12'h004 || beat_we[b0] !== 4'b1111 || beat_din[b0] !== 32'hDEADBEEF) begin
         bad++; $display("FAIL aligned_beat got addr=%h we=%b din=%h want 004 1111 deadbeef", beat_addr[b0], beat_we[b0], beat_din[b0]); end
      total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL aligned_rsp got rdata=%h err=%b want 0 0", rd, er); end
      r0 = nreads;
      do_req(1'b0, 14'h010, 2'b10, 1'b0, 32'h0, cyc, rd, er);
      total++; if (cyc !== 2) begin bad++; $display("FAIL aligned_load_latency got=%0d want=2", cyc); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL aligned_load got=%h want=deadbeef", rd); end
      total++; if (nreads - r0 !== 1 || rd_addr[r0] !== 12'h004) begin
         bad++; $display("FAIL aligned_load_reads got n=%0d addr=%h want 1 004", nreads - r0, rd_addr[r0]); end
      do_req(1'b0, 14'h013, 2'b00, 1'b1, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'hFFFFFFDE) begin bad++; $display("FAIL byte_signed_load got=%h want=ffffffde", rd); end
   endtask

   task automatic test_half_offset1();
      int b0, cyc; logic [31:0] rd; logic er;
      b0 = nbeats;
      do_req(1'b1, 14'h005, 2'b01, 1'b0, 32'h0000ABCD, cyc, rd, er);
      total++; if (cyc !== 2) begin bad++; $display("FAIL half_store_latency got=%0d want=2", cyc); end
      total++; if (nbeats - b0 !== 2) begin bad++; $display("FAIL half_store_beats got=%0d want=2", nbeats - b0); end
      total++; if (beat_addr[b0] !== 12'h001 || beat_we[b0] !== 4'b0010 || beat_din[b0][15:8] !== 8'hCD) begin
         bad++; $display("FAIL half_beat0 got addr=%h we=%b byte=%h want 001 0010 cd", beat_addr[b0], beat_we[b0], beat_din[b0][15:8]); end
      total++; if (beat_addr[b0+1] !== 12'h001 || beat_we[b0+1] !== 4'b0100 || beat_din[b0+1][23:16] !== 8'hAB) begin
         bad++; $display("FAIL half_beat1 got addr=%h we=%b byte=%h want 001 0100 ab", beat_addr[b0+1], beat_we[b0+1], beat_din[b0+1][23:16]); end
      do_req(1'b0, 14'h005, 2'b01, 1'b0, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'h0000ABCD || cyc !== 2) begin bad++; $display("FAIL half_load_u got=%h cyc=%0d want 0000abcd 2", rd, cyc); end
      do_req(1'b0, 14'h005, 2'b01, 1'b1, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'hFFFFABCD) begin bad++; $display("FAIL half_load_s got=%h want=ffffabcd", rd); end
      do_req(1'b0, 14'h006, 2'b00, 1'b1, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'hFFFFFFAB) begin bad++; $display("FAIL byte_load_s got=%h want=ffffffab", rd); end
   endtask

   task automatic test_word_offset3();
      int b0, r0, cyc; logic [31:0] rd; logic er;
      b0 = nbeats;
      do_req(1'b1, 14'h007, 2'b10, 1'b0, 32'h11223344, cyc, rd, er);
      total++; if (cyc !== 3 || nbeats - b0 !== 3) begin bad++; $display("FAIL word3_store got cyc=%0d beats=%0d want 3 3", cyc, nbeats - b0); end
      total++; if (beat_addr[b0] !== 12'h001 || beat_we[b0] !== 4'b1000 || beat_din[b0][31:24] !== 8'h44) begin
         bad++; $display("FAIL word3_beat0 got addr=%h we=%b byte=%h want 001 1000 44", beat_addr[b0], beat_we[b0], beat_din[b0][31:24]); end
      total++; if (beat_addr[b0+1] !== 12'h002 || beat_we[b0+1] !== 4'b0011 || beat_din[b0+1][15:0] !== 16'h2233) begin
         bad++; $display("FAIL word3_beat1 got addr=%h we=%b half=%h want 002 0011 2233", beat_addr[b0+1], beat_we[b0+1], beat_din[b0+1][15:0]); end
      total++; if (beat_addr[b0+2] !== 12'h002 || beat_we[b0+2] !== 4'b0100 || beat_din[b0+2][23:16] !== 8'h11) begin
         bad++; $display("FAIL word3_beat2 got addr=%h we=%b byte=%h want 002 0100 11", beat_addr[b0+2], beat_we[b0+2], beat_din[b0+2][23:16]); end
      r0 = nreads;
      do_req(1'b0, 14'h007, 2'b10, 1'b0, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'h11223344 || cyc !== 3) begin bad++; $display("FAIL word3_load got=%h cyc=%0d want 11223344 3", rd, cyc); end
      total++; if (nreads - r0 !== 2 || rd_addr[r0] !== 12'h001 || rd_addr[r0+1] !== 12'h002) begin
         bad++; $display("FAIL word3_reads got n=%0d a0=%h a1=%h want 2 001 002", nreads - r0, rd_addr[r0], rd_addr[r0+1]); end
      do_req(1'b0, 14'h007, 2'b01, 1'b0, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'h00003344 || cyc !== 3) begin bad++; $display("FAIL half3_load got=%h cyc=%0d want 00003344 3", rd, cyc); end
   endtask

   task automatic test_wrap();
      int b0, r0, cyc; logic [31:0] rd; logic er;
      do_req(1'b1, 14'h3FFC, 2'b10, 1'b0, 32'h55667788, cyc, rd, er);
      do_req(1'b1, 14'h0000, 2'b10, 1'b0, 32'h99AABBCC, cyc, rd, er);
      r0 = nreads;
      do_req(1'b0, 14'h3FFE, 2'b10, 1'b0, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'hBBCC5566) begin bad++; $display("FAIL wrap_load got=%h want=bbcc5566", rd); end
      total++; if (nreads - r0 !== 2 || rd_addr[r0] !== 12'hFFF || rd_addr[r0+1] !== 12'h000) begin
         bad++; $display("FAIL wrap_reads got n=%0d a0=%h a1=%h want 2 fff 000", nreads - r0, rd_addr[r0], rd_addr[r0+1]); end
      b0 = nbeats;
      do_req(1'b1, 14'h3FFF, 2'b01, 1'b0, 32'h0000E1F2, cyc, rd, er);
      total++; if (nbeats - b0 !== 2 || beat_addr[b0] !== 12'hFFF || beat_we[b0] !== 4'b1000 || beat_din[b0][31:24] !== 8'hF2) begin
         bad++; $display("FAIL wrap_store_beat0 got n=%0d addr=%h we=%b byte=%h want 2 fff 1000 f2", nbeats - b0, beat_addr[b0], beat_we[b0], beat_din[b0][31:24]); end
      total++; if (beat_addr[b0+1] !== 12'h000 || beat_we[b0+1] !== 4'b0001 || beat_din[b0+1][7:0] !== 8'hE1) begin
         bad++; $display("FAIL wrap_store_beat1 got addr=%h we=%b byte=%h want 000 0001 e1", beat_addr[b0+1], beat_we[b0+1], beat_din[b0+1][7:0]); end
      do_req(1'b0, 14'h3FFF, 2'b01, 1'b0, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'h0000E1F2) begin bad++; $display("FAIL wrap_half_load got=%h want=0000e1f2", rd); end
   endtask

   task automatic test_reset_mid_store();
      int b0, cyc; logic [31:0] rd; logic er;
      b0 = nbeats;
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 14'h007;
      bus.req_size = 2'b10; bus.req_signed = 1'b0; bus.req_wdata = 32'hAABBCCDD;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL abort_state got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready); end
      total++; if (nbeats - b0 !== 1 || beat_addr[b0] !== 12'h001 || beat_we[b0] !== 4'b1000) begin
         bad++; $display("FAIL abort_beats got n=%0d addr=%h we=%b want 1 001 1000", nbeats - b0, beat_addr[b0], beat_we[b0]); end
      do_req(1'b0, 14'h004, 2'b10, 1'b0, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'hDDABCD00) begin bad++; $display("FAIL abort_word1 got=%h want=ddabcd00", rd); end
      do_req(1'b0, 14'h008, 2'b10, 1'b0, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'h00112233) begin bad++; $display("FAIL abort_word2 got=%h want=00112233", rd); end
   endtask

   task automatic test_illegal_size();
      int e0, cyc; logic [31:0] rd; logic er;
      e0 = nen;
      do_req(1'b0, 14'h010, 2'b11, 1'b0, 32'h0, cyc, rd, er);
      total++; if (cyc !== 1 || er !== 1'b1 || rd !== 32'h0) begin
         bad++; $display("FAIL illegal_load got cyc=%0d err=%b rdata=%h want 1 1 0", cyc, er, rd); end
      do_req(1'b1, 14'h010, 2'b11, 1'b0, 32'hFFFFFFFF, cyc, rd, er);
      total++; if (cyc !== 1 || er !== 1'b1) begin bad++; $display("FAIL illegal_store got cyc=%0d err=%b want 1 1", cyc, er); end
      total++; if (nen !== e0) begin bad++; $display("FAIL illegal_ram_en got=%0d enabled cycles want=0", nen - e0); end
      @(posedge clk); #1;
      total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin
         bad++; $display("FAIL illegal_pulse got valid=%b err=%b want 0 0", bus.rsp_valid, bus.rsp_err); end
   endtask

   task automatic test_back_to_back();
      int cyc; logic [31:0] rd; logic er;
      do_req(1'b1, 14'h021, 2'b00, 1'b0, 32'h0000005A, cyc, rd, er);
      do_req(1'b0, 14'h021, 2'b00, 1'b1, 32'h0, cyc, rd, er);
      total++; if (rd !== 32'h0000005A || cyc !== 2) begin bad++; $display("FAIL b2b_load got=%h cyc=%0d want 0000005a 2", rd, cyc); end
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0000005A) begin
         bad++; $display("FAIL rdata_hold got valid=%b rdata=%h want 0 0000005a", bus.rsp_valid, bus.rsp_rdata); end
   endtask

   initial begin
      test_reset();
      test_aligned_store();
      test_half_offset1();
      test_word_offset3();
      test_wrap();
      test_reset_mid_store();
      test_illegal_size();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
